// File: rtl/pc_gen_unit_pkg.sv
// Shared op codes, default addresses and offset helper for the PC generator.
package pc_gen_unit_pkg;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_J   = 3'b001;
  localparam logic [2:0] NPC_BR  = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;
  localparam logic [2:0] NPC_RET = 3'b100;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  // Sign-extended word offset of a branch immediate.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_unit_ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_gen_unit_ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         valid_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] top_idx;
  logic [CntW-1:0] cnt_q;

  // ptr_q is the next free slot, so the top lives one below it.
  assign top_idx = ptr_q - PtrW'(1);
  assign top_o   = mem_q[top_idx];
  assign valid_o = (cnt_q != '0);

  // Buffer, pointer and occupancy update on push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      mem_q[ptr_q] <= din_i;
      ptr_q        <= ptr_q + PtrW'(1);
      if (cnt_q != CntW'(DEPTH)) cnt_q <= cnt_q + CntW'(1);
    end else if (pop_i && valid_o) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Architectural PC register with next-PC selection, exception entry/return and RAS prediction.
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC     = DEF_EXC_VEC,
  parameter int unsigned RAS_DEPTH   = 4,
  parameter bit          BR_BASE_PC4 = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        stall_i,
  input  logic [2:0]  npc_op_i,
  input  logic        link_i,
  input  logic [15:0] imm_16_i,
  input  logic [25:0] imm_26_i,
  input  logic [31:0] rs_val_i,
  input  logic        exc_req_i,
  input  logic        eret_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_add_4_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] ras_pred_o,
  output logic        ras_valid_o,
  output logic        ras_mispred_o
);

  logic [31:0] pc_q, pc_d, epc_q, epc_d, bad_q, bad_d;
  logic        mispred_q, mispred_d;
  logic        upd, reg_target, misalign, push, pop;
  logic [31:0] br_base;

  assign upd        = exc_req_i | (en_i & ~stall_i);
  assign pc_add_4_o = pc_q + 32'd4;
  assign br_base    = BR_BASE_PC4 ? pc_add_4_o : pc_q;
  assign reg_target = (npc_op_i == NPC_JR) || (npc_op_i == NPC_RET);
  assign misalign   = reg_target && (rs_val_i[1:0] != 2'b00);

  // Next-PC priority: exception, eret, misaligned register target, then op.
  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    bad_d     = bad_q;
    push      = 1'b0;
    pop       = 1'b0;
    mispred_d = 1'b0;
    if (exc_req_i) begin
      pc_d  = EXC_VEC;
      epc_d = pc_q;
    end else if (upd) begin
      if (eret_i) begin
        pc_d = epc_q;
      end else if (misalign) begin
        pc_d  = EXC_VEC;
        epc_d = pc_q;
        bad_d = rs_val_i;
      end else begin
        case (npc_op_i)
          NPC_J: begin
            pc_d = {pc_q[31:28], imm_26_i, 2'b00};
            push = link_i;
          end
          NPC_BR: pc_d = br_base + br_offset(imm_16_i);
          NPC_JR: begin
            pc_d = rs_val_i;
            push = link_i;
          end
          NPC_RET: begin
            pc_d      = rs_val_i;
            pop       = 1'b1;
            mispred_d = !ras_valid_o || (rs_val_i != ras_pred_o);
          end
          default: pc_d = pc_add_4_o;
        endcase
      end
    end
  end

  // State registers; mispredict is rewritten every cycle so it only pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      epc_q     <= '0;
      bad_q     <= '0;
      mispred_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      bad_q     <= bad_d;
      mispred_q <= mispred_d;
    end
  end

  pc_gen_unit_ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (32)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_add_4_o),
    .top_o   (ras_pred_o),
    .valid_o (ras_valid_o)
  );

  assign pc_o          = pc_q;
  assign epc_o         = epc_q;
  assign badvaddr_o    = bad_q;
  assign ras_mispred_o = mispred_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit; a second instance covers the PC-relative branch base.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, stall, link, exc_req, eret;
  logic [2:0]  npc_op;
  logic [15:0] imm_16;
  logic [25:0] imm_26;
  logic [31:0] rs_val;

  logic [31:0] pc, pc_add_4, epc, badvaddr, ras_pred;
  logic        ras_valid, ras_mispred;
  logic [31:0] pc0, pc_add_40, epc0, badvaddr0, ras_pred0;
  logic        ras_valid0, ras_mispred0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pc_gen_unit #(.BR_BASE_PC4(1'b1)) dut (
    .clk (clk), .rst_n (rst_n), .en_i (en), .stall_i (stall), .npc_op_i (npc_op),
    .link_i (link), .imm_16_i (imm_16), .imm_26_i (imm_26), .rs_val_i (rs_val),
    .exc_req_i (exc_req), .eret_i (eret), .pc_o (pc), .pc_add_4_o (pc_add_4),
    .epc_o (epc), .badvaddr_o (badvaddr), .ras_pred_o (ras_pred),
    .ras_valid_o (ras_valid), .ras_mispred_o (ras_mispred)
  );

  pc_gen_unit #(.BR_BASE_PC4(1'b0)) dut0 (
    .clk (clk), .rst_n (rst_n), .en_i (en), .stall_i (stall), .npc_op_i (npc_op),
    .link_i (link), .imm_16_i (imm_16), .imm_26_i (imm_26), .rs_val_i (rs_val),
    .exc_req_i (exc_req), .eret_i (eret), .pc_o (pc0), .pc_add_4_o (pc_add_40),
    .epc_o (epc0), .badvaddr_o (badvaddr0), .ras_pred_o (ras_pred0),
    .ras_valid_o (ras_valid0), .ras_mispred_o (ras_mispred0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rets [4];
    rets[0] = 32'h404; rets[1] = 32'h304; rets[2] = 32'h204; rets[3] = 32'h104;

    rst_n = 1'b0; en = 1'b0; stall = 1'b0; link = 1'b0; exc_req = 1'b0; eret = 1'b0;
    npc_op = 3'b000; imm_16 = '0; imm_26 = '0; rs_val = '0;
    #12;
    check("rst_pc", pc, 32'h3000);
    check("rst_epc", epc, 32'h0);
    check("rst_bad", badvaddr, 32'h0);
    check("rst_ras_valid", 32'(ras_valid), 32'h0);
    check("rst_mispred", 32'(ras_mispred), 32'h0);

    // 1: sequential fetch
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1;
    check("seq_pc0", pc, 32'h3000);
    check("seq_pc4_0", pc_add_4, 32'h3004);
    step(); check("seq_pc1", pc, 32'h3004); check("seq_pc4_1", pc_add_4, 32'h3008);
    step(); check("seq_pc2", pc, 32'h3008);
    step(); check("seq_pc3", pc, 32'h300C); check("seq_pc4_3", pc_add_4, 32'h3010);
    step(); check("seq_pc4", pc, 32'h3010); check("seq_pc4_b0", pc0, 32'h3010);

    // 2: branch with offset -1 word, both base selections
    npc_op = 3'b010; imm_16 = 16'hFFFF;
    step();
    check("br_base_pc4", pc, 32'h3010);
    check("br_base_pc", pc0, 32'h300C);

    // Asynchronous reset mid-stream
    npc_op = 3'b000; imm_16 = '0;
    rst_n = 1'b0; #1;
    check("async_rst_pc", pc, 32'h3000);
    check("async_rst_pc_b0", pc0, 32'h3000);
    rst_n = 1'b1;

    // 3: jal then correctly predicted return
    npc_op = 3'b001; link = 1'b1; imm_26 = 26'h400;
    step();
    check("jal_pc", pc, 32'h0000_1000);
    check("jal_ras_pred", ras_pred, 32'h3004);
    check("jal_ras_valid", 32'(ras_valid), 32'h1);
    npc_op = 3'b100; link = 1'b0; rs_val = 32'h3004;
    step();
    check("ret_pc", pc, 32'h3004);
    check("ret_mispred", 32'(ras_mispred), 32'h0);
    check("ret_ras_valid", 32'(ras_valid), 32'h0);

    // 4: five calls into a 4-deep RAS, pcs 3004,100,200,300,400
    npc_op = 3'b001; link = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      imm_26 = 26'(i * 32'h40);
      step();
    end
    check("calls_pc", pc, 32'h500);
    check("calls_ras_pred", ras_pred, 32'h404);
    npc_op = 3'b100; link = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ras_pred_%0d", i), ras_pred, rets[i]);
      rs_val = rets[i];
      step();
      check($sformatf("ret_pc_%0d", i), pc, rets[i]);
      check($sformatf("ret_mispred_%0d", i), 32'(ras_mispred), 32'h0);
    end
    check("ras_empty", 32'(ras_valid), 32'h0);
    rs_val = 32'h104;
    step();
    check("empty_ret_pc", pc, 32'h104);
    check("empty_ret_mispred", 32'(ras_mispred), 32'h1);
    npc_op = 3'b000;
    step();
    check("mispred_pulse_end", 32'(ras_mispred), 32'h0);
    check("seq_after_ret", pc, 32'h108);

    // 5: misaligned jr then eret
    npc_op = 3'b011; rs_val = 32'h0000_2002;
    step();
    check("misal_pc", pc, 32'h4180);
    check("misal_epc", epc, 32'h108);
    check("misal_bad", badvaddr, 32'h2002);
    check("misal_ras", 32'(ras_valid), 32'h0);
    npc_op = 3'b000; eret = 1'b1;
    step();
    check("eret_pc", pc, 32'h108);
    eret = 1'b0;

    // 6: stall holds, stall with exception does not
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step(); step();
    check("pre_stall_pc", pc, 32'h3008);
    stall = 1'b1;
    step();
    check("stall_hold", pc, 32'h3008);
    exc_req = 1'b1;
    step();
    check("stall_exc_pc", pc, 32'h4180);
    check("stall_exc_epc", epc, 32'h3008);
    exc_req = 1'b0; stall = 1'b0; en = 1'b0;
    step();
    check("en_low_hold", pc, 32'h4180);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
